sd_frame_serializer: RTL and testbench
======================================

Name: sd_frame_serializer

Overview:
- Parametrised parallel-in/serial-out transmitter for the SD host command path.
- Accepts a frame of up to BITS bits over a valid/ready handshake, with a per-frame length and selectable bit order.
- Shifts the frame onto a single line, one bit per enabled clock edge, then optionally appends a CRC7 and an end bit.
- Drives an output-enable for the tri-state CMD pad, holds the line at its idle level between frames, and pulses done on completion.

Parameters:
- BITS, 48, maximum data bits per frame.
- BITS_COUNTER, 6, width of the bit counter and in_len; must be >= clog2(BITS+1).
- MSB_FIRST, 1, 1 = send in_data[len-1] first; 0 = send in_data[0] first.
- CRC_EN, 1, 1 = append CRC7 (x^7+x^3+1, init 0) of the data bits after the data.
- END_BIT, 1, 1 = append a single '1' after the data/CRC.
- IDLE_LEVEL, 1, line value while idle or in reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  bit strobe; state advances only on clk edges where enable=1.
- in_valid  in  1  frame offered.
- in_ready  out  1  block can accept a frame.
- in_data  in  BITS  frame payload, right-aligned.
- in_len  in  BITS_COUNTER  data bit count; 0 or >BITS means BITS.
- out  out  1  serial line (registered).
- out_oe  out  1  pad drive enable (registered).
- busy  out  1  frame in progress.
- done  out  1  one-cycle completion pulse (registered).

Behaviour:
- Reset (async, any state): state=IDLE, out=IDLE_LEVEL, out_oe=0, done=0, counter=0, crc=0. in_ready is forced to 0 while reset is high.
- Decided interface fact: one clock; reset is asynchronous and active-high (ports clk, reset).
- States: IDLE, DATA, CRC (only if CRC_EN), END (only if END_BIT).
- All transitions listed below require enable=1 on that edge. With enable=0, every register holds, including the current out bit.
- in_ready = (state==IDLE) && !reset. busy = (state!=IDLE).
- IDLE -> DATA on an edge with in_valid && in_ready && enable. On that edge:
  - latch in_data and the effective len L;
  - out <= first bit; out_oe <= 1; counter <= 1; crc <= crc7_step(0, first bit).
- in_valid with enable=0 is not accepted, so the first bit gets a full bit period.
- DATA: while counter < L, out <= next bit; counter++; crc updated with the bit placed on out.
- When counter == L: go to CRC if CRC_EN, else END if END_BIT, else IDLE.
  - Entering CRC: out <= crc[6]; crc <= crc<<1; counter <= 1.
  - Entering END: out <= 1.
- CRC: emits crc[6] MSB-first for 7 bit periods, then goes to END or IDLE.
- END: one bit period of '1', then IDLE.
- Entering IDLE from any state: out <= IDLE_LEVEL; out_oe <= 0; done <= 1 for exactly one clk cycle.
- Total enabled edges from accept to the return to IDLE: L + 7*CRC_EN + END_BIT.
- A new frame is accepted no earlier than the first enabled edge after the return to IDLE. There is no same-edge reload, so frames are separated by at least one bit period at IDLE_LEVEL.
- in_valid or in_data changes while busy are ignored; the latched copy is used.
- L=1 is legal: one data bit, then CRC/END.
- Reset mid-frame aborts immediately with no done pulse. The line returns to IDLE_LEVEL and out_oe=0 asynchronously.

Test Plan:
- CMD0: defaults, enable=1, in_data=0x40_0000_0000, in_len=40.
  - out stream must be 0x400000000095 MSB-first over 48 edges.
  - out_oe=1 throughout; done pulses once at edge 48; busy high for 48 cycles.
- CMD8 and CMD17: in_data=0x48_0000_01AA and 0x51_0000_0000, len 40.
  - Stream must be 0x48000001AA87 and 0x510000000055 (CRC 0x43 and 0x2A).
- Enable gating: enable high one clk in four, CMD0 frame.
  - Identical bit sequence; each bit held exactly 4 clks; done after 192 clks.
  - Offering in_valid on an enable=0 edge must not accept the frame.
- LSB-first, no CRC: MSB_FIRST=0, CRC_EN=0, END_BIT=0, in_data=0xA5, len 8.
  - out must be 1,0,1,0,0,1,0,1, then IDLE_LEVEL; done at edge 8.
- len edge cases: in_len=0 must send 48 data bits (0-/clamp-to-BITS check). in_len=1 with in_data=1 must send 1, then CRC7(1)=0x09, then 1.
- Reset and back-to-back:
  - Assert reset at bit 20 of a frame: out=1 and out_oe=0 before the next clk edge; no done; next frame sends a correct CRC.
  - Hold in_valid high continuously: second frame starts exactly one enabled edge after the first done.

Source files
------------

// File: rtl/sd_frame_serializer.sv
// sd_frame_serializer: parallel-in/serial-out transmitter for the SD CMD line.
// A frame of up to BITS bits is shifted out one bit per enabled clock edge,
// followed by an optional CRC7 (x^7+x^3+1) and an optional '1' end bit.
module sd_frame_serializer #(
   parameter int unsigned BITS         = 48,
   parameter int unsigned BITS_COUNTER = 6,
   parameter bit          MSB_FIRST    = 1'b1,
   parameter bit          CRC_EN       = 1'b1,
   parameter bit          END_BIT      = 1'b1,
   parameter bit          IDLE_LEVEL   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BITS-1:0]         in_data,
   input  logic [BITS_COUNTER-1:0] in_len,
   output logic                    out,
   output logic                    out_oe,
   output logic                    busy,
   output logic                    done
);

   // Counter is also reused for the 7 CRC bits, so it needs at least 3 bits.
   localparam int unsigned CW = (BITS_COUNTER > 3) ? BITS_COUNTER : 3;
   localparam logic [BITS_COUNTER-1:0] MaxLen = BITS_COUNTER'(BITS);

   typedef enum logic [1:0] {StIdle, StData, StCrc, StEnd} state_t;

   state_t                  state;
   logic [BITS-1:0]         shreg;
   logic [CW-1:0]           len;
   logic [CW-1:0]           counter;
   logic [6:0]              crc;

   logic [BITS_COUNTER-1:0] eff_len;
   logic [BITS-1:0]         aligned;
   logic [BITS-1:0]         first_shreg;
   logic [BITS-1:0]         shifted;
   logic                    first_bit;
   logic                    next_bit;

   // One serial CRC7 step: feedback taps at x^3 and x^0.
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:3], c[2] ^ fb, c[1:0], fb};
   endfunction

   assign in_ready = (state == StIdle) && !reset;
   assign busy     = (state != StIdle);

   // Effective length plus first/next bit selection for the configured bit order.
   always_comb begin
      eff_len = in_len;
      if (in_len == '0 || in_len > MaxLen) begin
         eff_len = MaxLen;
      end
      // Left-align the payload so the MSB-first stream always leaves from bit BITS-1.
      aligned = in_data << (MaxLen - eff_len);
      if (MSB_FIRST) begin
         first_bit   = aligned[BITS-1];
         first_shreg = aligned << 1;
         next_bit    = shreg[BITS-1];
         shifted     = shreg << 1;
      end else begin
         first_bit   = in_data[0];
         first_shreg = in_data >> 1;
         next_bit    = shreg[0];
         shifted     = shreg >> 1;
      end
   end

   // Frame FSM; every register, including out, holds on edges without enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= StIdle;
         out     <= IDLE_LEVEL;
         out_oe  <= 1'b0;
         done    <= 1'b0;
         counter <= '0;
         len     <= '0;
         crc     <= '0;
         shreg   <= '0;
      end else begin
         done <= 1'b0;
         if (enable) begin
            case (state)
               StIdle: begin
                  if (in_valid && in_ready) begin
                     state   <= StData;
                     out     <= first_bit;
                     out_oe  <= 1'b1;
                     counter <= CW'(1);
                     len     <= CW'(eff_len);
                     shreg   <= first_shreg;
                     crc     <= crc7_step(7'd0, first_bit);
                  end
               end
               StData: begin
                  if (counter < len) begin
                     out     <= next_bit;
                     shreg   <= shifted;
                     counter <= counter + CW'(1);
                     crc     <= crc7_step(crc, next_bit);
                  end else if (CRC_EN) begin
                     state   <= StCrc;
                     out     <= crc[6];
                     crc     <= {crc[5:0], 1'b0};
                     counter <= CW'(1);
                  end else if (END_BIT) begin
                     state <= StEnd;
                     out   <= 1'b1;
                  end else begin
                     state  <= StIdle;
                     out    <= IDLE_LEVEL;
                     out_oe <= 1'b0;
                     done   <= 1'b1;
                  end
               end
               StCrc: begin
                  if (counter < CW'(7)) begin
                     out     <= crc[6];
                     crc     <= {crc[5:0], 1'b0};
                     counter <= counter + CW'(1);
                  end else if (END_BIT) begin
                     state <= StEnd;
                     out   <= 1'b1;
                  end else begin
                     state  <= StIdle;
                     out    <= IDLE_LEVEL;
                     out_oe <= 1'b0;
                     done   <= 1'b1;
                  end
               end
               StEnd: begin
                  state  <= StIdle;
                  out    <= IDLE_LEVEL;
                  out_oe <= 1'b0;
                  done   <= 1'b1;
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_frame_serializer.sv
// Bench for sd_frame_serializer: table of known SD commands, randomized frames
// against a polynomial-division reference model, and hand-written corner cases.
module tb_sd_frame_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        in_valid;
   logic        in_valid_b;
   logic [47:0] in_data;
   logic [5:0]  in_len;

   logic in_ready_a, out_a, oe_a, busy_a, done_a;
   logic in_ready_b, out_b, oe_b, busy_b, done_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sd_frame_serializer dut_a (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .in_valid (in_valid),
      .in_ready (in_ready_a),
      .in_data  (in_data),
      .in_len   (in_len),
      .out      (out_a),
      .out_oe   (oe_a),
      .busy     (busy_a),
      .done     (done_a)
   );

   sd_frame_serializer #(
      .MSB_FIRST (1'b0),
      .CRC_EN    (1'b0),
      .END_BIT   (1'b0)
   ) dut_b (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .in_valid (in_valid_b),
      .in_ready (in_ready_b),
      .in_data  (in_data),
      .in_len   (in_len),
      .out      (out_b),
      .out_oe   (oe_b),
      .busy     (busy_b),
      .done     (done_b)
   );

   typedef struct {
      logic [47:0] data;
      logic [5:0]  len;
      logic [63:0] exp;
      int          n;
   } vec_t;

   // Results of the most recent run_frame call.
   logic [63:0] got;
   int          nbits, done_clk, done_cnt, busy_cnt;
   bit          oe_ok, hold_ok, gate_ok;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic out_of(input bit w);
      return w ? out_b : out_a;
   endfunction
   function automatic logic oe_of(input bit w);
      return w ? oe_b : oe_a;
   endfunction
   function automatic logic busy_of(input bit w);
      return w ? busy_b : busy_a;
   endfunction
   function automatic logic done_of(input bit w);
      return w ? done_b : done_a;
   endfunction

   // Reference: data bits in transmission order, CRC7 as the remainder of
   // M(x)*x^7 divided by x^7+x^3+1 (long division), then the end bit.
   function automatic void model(input logic [47:0] data, input logic [5:0] len, input bit msb,
                                 input bit crc_en, input bit end_en,
                                 output logic [63:0] exp, output int n);
      int         l;
      bit         m[$];
      bit         b;
      logic [7:0] g;
      g   = 8'h89;
      l   = (len == 0 || len > 48) ? 48 : int'(len);
      exp = '0;
      n   = 0;
      for (int i = 0; i < l; i++) begin
         b = msb ? data[l-1-i] : data[i];
         m.push_back(b);
         exp = {exp[62:0], b};
         n++;
      end
      if (crc_en) begin
         for (int i = 0; i < 7; i++) m.push_back(1'b0);
         for (int i = 0; i < l; i++) begin
            if (m[i]) begin
               for (int j = 0; j < 8; j++) m[i+j] = m[i+j] ^ g[7-j];
            end
         end
         for (int i = 0; i < 7; i++) begin
            exp = {exp[62:0], m[l+i]};
            n++;
         end
      end
      if (end_en) begin
         exp = {exp[62:0], 1'b1};
         n++;
      end
   endfunction

   // Offer one frame and capture every bit placed on the line until done.
   task automatic run_frame(input bit which, input logic [47:0] data, input logic [5:0] len,
                            input int period, input int phase);
      bit started, en_now, last;
      int acc_c, post;
      got = '0; nbits = 0; done_clk = -1; done_cnt = 0; busy_cnt = 0;
      oe_ok = 1'b1; hold_ok = 1'b1; gate_ok = 1'b1;
      started = 1'b0; acc_c = 0; post = 0; last = 1'b0;
      in_data = data;
      in_len  = len;
      if (which) in_valid_b = 1'b1;
      else in_valid = 1'b1;
      for (int c = 0; c < 600; c++) begin
         en_now = ((c + phase) % period == 0);
         enable = en_now;
         tick();
         if (!started && busy_of(which)) begin
            if (!en_now) gate_ok = 1'b0;
            started    = 1'b1;
            acc_c      = c;
            in_valid   = 1'b0;
            in_valid_b = 1'b0;
         end
         if (started) begin
            if (busy_of(which)) busy_cnt++;
            if (done_of(which)) begin
               done_cnt++;
               if (done_clk < 0) done_clk = c - acc_c;
            end
            if (done_clk < 0) begin
               if (!oe_of(which)) oe_ok = 1'b0;
               if (en_now) begin
                  got  = {got[62:0], out_of(which)};
                  last = out_of(which);
                  nbits++;
               end else if (out_of(which) !== last) begin
                  hold_ok = 1'b0;
               end
            end else begin
               post++;
               if (oe_of(which) !== 1'b0 || out_of(which) !== 1'b1) oe_ok = 1'b0;
               if (post > 3) break;
            end
         end
      end
      enable     = 1'b1;
      in_valid   = 1'b0;
      in_valid_b = 1'b0;
   endtask

   task automatic check_frame(input string name, input logic [63:0] exp, input int n);
      check({name, " stream"}, got, exp);
      check({name, " nbits"}, 64'(nbits), 64'(n));
      check({name, " done_at"}, 64'(done_clk), 64'(n));
      check({name, " done_pulses"}, 64'(done_cnt), 64'd1);
      check({name, " busy_cycles"}, 64'(busy_cnt), 64'(n));
      check({name, " oe/idle"}, 64'(oe_ok), 64'd1);
   endtask

   initial begin
      vec_t        tbl[4];
      logic [63:0] exp, exp2;
      int          n, n2;
      logic [47:0] rdata;
      logic [5:0]  rlen;

      tbl[0] = '{data: 48'h40_0000_0000, len: 6'd40, exp: 64'h4000_0000_0095, n: 48};
      tbl[1] = '{data: 48'h48_0000_01AA, len: 6'd40, exp: 64'h4800_0001_AA87, n: 48};
      tbl[2] = '{data: 48'h51_0000_0000, len: 6'd40, exp: 64'h5100_0000_0055, n: 48};
      tbl[3] = '{data: 48'h1,            len: 6'd1,  exp: 64'h113,            n: 9};

      reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0;
      in_data = '0; in_len = '0;
      #1;
      check("reset out", 64'(out_a), 64'd1);
      check("reset oe", 64'(oe_a), 64'd0);
      check("reset done", 64'(done_a), 64'd0);
      check("reset busy", 64'(busy_a), 64'd0);
      check("reset in_ready", 64'(in_ready_a), 64'd0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("idle in_ready", 64'(in_ready_a), 64'd1);

      // Known command frames.
      for (int i = 0; i < 4; i++) begin
         run_frame(1'b0, tbl[i].data, tbl[i].len, 1, 0);
         check_frame($sformatf("table[%0d]", i), tbl[i].exp, tbl[i].n);
      end

      // Enable one clock in four; first three offered edges are disabled.
      run_frame(1'b0, 48'h40_0000_0000, 6'd40, 4, 1);
      check("gated stream", got, 64'h4000_0000_0095);
      check("gated nbits", 64'(nbits), 64'd48);
      check("gated done_at", 64'(done_clk), 64'd192);
      check("gated hold", 64'(hold_ok), 64'd1);
      check("gated no_accept_when_disabled", 64'(gate_ok), 64'd1);
      check("gated done_pulses", 64'(done_cnt), 64'd1);

      // LSB-first, no CRC, no end bit.
      run_frame(1'b1, 48'hA5, 6'd8, 1, 0);
      check_frame("lsb A5", 64'hA5, 8);

      // len = 0 clamps to 48 data bits.
      rdata = {$urandom, $urandom};
      model(rdata, 6'd0, 1'b1, 1'b1, 1'b1, exp, n);
      run_frame(1'b0, rdata, 6'd0, 1, 0);
      check_frame("len0", exp, n);

      // Randomized frames against the model.
      for (int i = 0; i < 8; i++) begin
         rdata = {$urandom, $urandom};
         rlen  = 6'($urandom_range(0, 63));
         model(rdata, rlen, 1'b1, 1'b1, 1'b1, exp, n);
         run_frame(1'b0, rdata, rlen, 1, 0);
         check_frame($sformatf("rand_a[%0d] len %0d", i, rlen), exp, n);
      end
      for (int i = 0; i < 4; i++) begin
         rdata = {$urandom, $urandom};
         rlen  = 6'($urandom_range(1, 63));
         model(rdata, rlen, 1'b0, 1'b0, 1'b0, exp, n);
         run_frame(1'b1, rdata, rlen, 1, 0);
         check_frame($sformatf("rand_b[%0d] len %0d", i, rlen), exp, n);
      end

      // Reset at bit 20 of a CMD0 frame.
      in_data = 48'h40_0000_0000; in_len = 6'd40; enable = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (19) tick();
      check("mid busy", 64'(busy_a), 64'd1);
      #3 reset = 1'b1;
      #1;
      check("abort out", 64'(out_a), 64'd1);
      check("abort oe", 64'(oe_a), 64'd0);
      check("abort busy", 64'(busy_a), 64'd0);
      check("abort in_ready", 64'(in_ready_a), 64'd0);
      tick();
      check("abort no done", 64'(done_a), 64'd0);
      #3 reset = 1'b0;
      run_frame(1'b0, 48'h48_0000_01AA, 6'd40, 1, 0);
      check_frame("after reset", 64'h4800_0001_AA87, 48);

      // Back-to-back with in_valid held high; data change while busy ignored.
      in_data = 48'h40_0000_0000; in_len = 6'd40; enable = 1'b1; in_valid = 1'b1;
      tick();
      in_data = 48'h51_0000_0000;
      exp = {63'd0, out_a};
      n = 1;
      for (int c = 0; c < 100 && !done_a; c++) begin
         tick();
         if (!done_a) begin
            exp = {exp[62:0], out_a};
            n++;
         end
      end
      check("b2b first stream", exp, 64'h4000_0000_0095);
      check("b2b first nbits", 64'(n), 64'd48);
      check("b2b first done", 64'(done_a), 64'd1);
      check("b2b idle gap", 64'(busy_a), 64'd0);
      tick();
      check("b2b restart busy", 64'(busy_a), 64'd1);
      check("b2b restart oe", 64'(oe_a), 64'd1);
      in_valid = 1'b0;
      exp2 = {63'd0, out_a};
      n2 = 1;
      for (int c = 0; c < 100 && !done_a; c++) begin
         tick();
         if (!done_a) begin
            exp2 = {exp2[62:0], out_a};
            n2++;
         end
      end
      check("b2b second stream", exp2, 64'h5100_0000_0055);
      check("b2b second nbits", 64'(n2), 64'd48);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
